// File: rtl/uart_bus_sched.sv
// Register-port scheduler for uart_regs: runs the fixed init write sequence, then shares
// the single-strobe wishbone-style port between two clients with a guaranteed idle gap.

module uart_bus_sched #(
   parameter int ADDR_WIDTH = 3,
   parameter bit AUTO_INIT  = 1'b1
) (
   input  logic                  clk,
   input  logic                  wb_rst_i,
   input  logic                  cfg_start,
   input  logic [15:0]           cfg_divisor,
   input  logic [7:0]            cfg_lcr,
   input  logic [1:0]            cfg_fcr_tl,
   input  logic [3:0]            cfg_ier,
   output logic                  cfg_busy,
   output logic                  cfg_done,
   input  logic                  c0_req,
   input  logic                  c0_we,
   input  logic [ADDR_WIDTH-1:0] c0_addr,
   input  logic [7:0]            c0_wdata,
   output logic                  c0_ack,
   output logic [7:0]            c0_rdata,
   input  logic                  c1_req,
   input  logic                  c1_we,
   input  logic [ADDR_WIDTH-1:0] c1_addr,
   input  logic [7:0]            c1_wdata,
   output logic                  c1_ack,
   output logic [7:0]            c1_rdata,
   output logic [ADDR_WIDTH-1:0] wb_addr_o,
   output logic [7:0]            wb_dat_o,
   output logic                  wb_we_o,
   output logic                  wb_re_o,
   input  logic [7:0]            wb_dat_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STROBE = 2'd1,
      GAP    = 2'd2
   } state_t;

   localparam logic [1:0] SRC_C0    = 2'd0;
   localparam logic [1:0] SRC_C1    = 2'd1;
   localparam logic [1:0] SRC_INIT  = 2'd2;
   localparam logic [2:0] LAST_STEP = 3'd5;

   // {addr, data} of init step; lcr arrives with bit7 already cleared, DLAB is set around the DL writes
   function automatic logic [ADDR_WIDTH+7:0] init_word(
      input logic [2:0]  step,
      input logic [15:0] div,
      input logic [7:0]  lcr,
      input logic [1:0]  tl,
      input logic [3:0]  ier
   );
      logic [ADDR_WIDTH+7:0] w;
      case (step)
         3'd0:    w = {ADDR_WIDTH'(3'd3), lcr | 8'h80};
         3'd1:    w = {ADDR_WIDTH'(3'd0), div[7:0]};
         3'd2:    w = {ADDR_WIDTH'(3'd1), div[15:8]};
         3'd3:    w = {ADDR_WIDTH'(3'd3), lcr};
         3'd4:    w = {ADDR_WIDTH'(3'd2), tl, 6'b000110};
         3'd5:    w = {ADDR_WIDTH'(3'd1), 4'b0000, ier};
         default: w = {(ADDR_WIDTH+8){1'b0}};
      endcase
      return w;
   endfunction

   state_t                state_r, state_s;
   logic [1:0]            src_r, src_s;
   logic [2:0]            step_r, step_s;
   logic                  init_pend_r, init_pend_s;
   logic                  last_grant_r, last_grant_s;
   logic [15:0]           div_r;
   logic [7:0]            lcr_r;
   logic [1:0]            tl_r;
   logic [3:0]            ier_r;
   logic                  snap_s;

   logic [ADDR_WIDTH-1:0] wb_addr_s;
   logic [7:0]            wb_dat_s;
   logic                  wb_we_s, wb_re_s;
   logic                  c0_ack_s, c1_ack_s;
   logic [7:0]            c0_rdata_s, c1_rdata_s;
   logic                  busy_s, done_s;

   logic                  grant_ok_s, req0_s, req1_s, gvalid_s, gsel_s;

   // Round-robin choice; in a client GAP the client being acked is masked so it cannot be re-granted
   always_comb begin
      grant_ok_s = cfg_done && ((state_r == IDLE) || ((state_r == GAP) && (src_r != SRC_INIT)));
      req0_s     = c0_req && grant_ok_s && !((state_r == GAP) && (src_r == SRC_C0));
      req1_s     = c1_req && grant_ok_s && !((state_r == GAP) && (src_r == SRC_C1));
      gvalid_s   = req0_s || req1_s;
      if (req0_s && req1_s) begin
         gsel_s = ~last_grant_r;
      end else if (req1_s) begin
         gsel_s = 1'b1;
      end else begin
         gsel_s = 1'b0;
      end
   end

   // Next-state and next-output logic of the IDLE/STROBE/GAP sequencer
   always_comb begin
      state_s      = state_r;
      src_s        = src_r;
      step_s       = step_r;
      last_grant_s = last_grant_r;
      init_pend_s  = init_pend_r || (cfg_start && !cfg_busy);
      snap_s       = 1'b0;
      wb_addr_s    = {ADDR_WIDTH{1'b0}};
      wb_dat_s     = 8'h00;
      wb_we_s      = 1'b0;
      wb_re_s      = 1'b0;
      c0_ack_s     = 1'b0;
      c1_ack_s     = 1'b0;
      c0_rdata_s   = c0_rdata;
      c1_rdata_s   = c1_rdata;
      busy_s       = cfg_busy;
      done_s       = cfg_done;

      case (state_r)
         IDLE: begin
            if (init_pend_s) begin
               snap_s                 = 1'b1;
               init_pend_s            = 1'b0;
               src_s                  = SRC_INIT;
               step_s                 = 3'd0;
               busy_s                 = 1'b1;
               {wb_addr_s, wb_dat_s}  = init_word(3'd0, cfg_divisor, cfg_lcr & 8'h7F,
                                                  cfg_fcr_tl, cfg_ier);
               wb_we_s                = 1'b1;
               state_s                = STROBE;
            end else if (gvalid_s) begin
               src_s        = {1'b0, gsel_s};
               last_grant_s = gsel_s;
               state_s      = STROBE;
               if (gsel_s) begin
                  wb_addr_s = c1_addr;
                  wb_dat_s  = c1_we ? c1_wdata : 8'h00;
                  wb_we_s   = c1_we;
                  wb_re_s   = !c1_we;
               end else begin
                  wb_addr_s = c0_addr;
                  wb_dat_s  = c0_we ? c0_wdata : 8'h00;
                  wb_we_s   = c0_we;
                  wb_re_s   = !c0_we;
               end
            end else begin
               state_s = IDLE;
            end
         end

         STROBE: begin
            state_s = GAP;
            if (src_r == SRC_C0) begin
               c0_ack_s = 1'b1;
               if (wb_re_o) begin
                  c0_rdata_s = wb_dat_i;
               end else begin
                  c0_rdata_s = c0_rdata;
               end
            end else if (src_r == SRC_C1) begin
               c1_ack_s = 1'b1;
               if (wb_re_o) begin
                  c1_rdata_s = wb_dat_i;
               end else begin
                  c1_rdata_s = c1_rdata;
               end
            end else begin
               c0_ack_s = 1'b0;
            end
         end

         GAP: begin
            if (src_r == SRC_INIT) begin
               if (step_r == LAST_STEP) begin
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
                  state_s = IDLE;
               end else begin
                  step_s                = step_r + 3'd1;
                  {wb_addr_s, wb_dat_s} = init_word(step_r + 3'd1, div_r, lcr_r, tl_r, ier_r);
                  wb_we_s               = 1'b1;
                  state_s               = STROBE;
               end
            end else if (init_pend_s) begin
               // a pending init may only launch from IDLE
               state_s = IDLE;
            end else if (gvalid_s) begin
               src_s        = {1'b0, gsel_s};
               last_grant_s = gsel_s;
               state_s      = STROBE;
               if (gsel_s) begin
                  wb_addr_s = c1_addr;
                  wb_dat_s  = c1_we ? c1_wdata : 8'h00;
                  wb_we_s   = c1_we;
                  wb_re_s   = !c1_we;
               end else begin
                  wb_addr_s = c0_addr;
                  wb_dat_s  = c0_we ? c0_wdata : 8'h00;
                  wb_we_s   = c0_we;
                  wb_re_s   = !c0_we;
               end
            end else begin
               state_s = IDLE;
            end
         end

         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, configuration snapshot and registered outputs
   always_ff @(posedge clk) begin
      if (wb_rst_i) begin
         state_r      <= IDLE;
         src_r        <= SRC_C0;
         step_r       <= 3'd0;
         init_pend_r  <= AUTO_INIT;
         last_grant_r <= 1'b1;
         div_r        <= 16'h0000;
         lcr_r        <= 8'h00;
         tl_r         <= 2'b00;
         ier_r        <= 4'h0;
         wb_addr_o    <= {ADDR_WIDTH{1'b0}};
         wb_dat_o     <= 8'h00;
         wb_we_o      <= 1'b0;
         wb_re_o      <= 1'b0;
         c0_ack       <= 1'b0;
         c1_ack       <= 1'b0;
         c0_rdata     <= 8'h00;
         c1_rdata     <= 8'h00;
         cfg_busy     <= 1'b0;
         cfg_done     <= 1'b0;
      end else begin
         state_r      <= state_s;
         src_r        <= src_s;
         step_r       <= step_s;
         init_pend_r  <= init_pend_s;
         last_grant_r <= last_grant_s;
         if (snap_s) begin
            div_r <= cfg_divisor;
            lcr_r <= cfg_lcr & 8'h7F;
            tl_r  <= cfg_fcr_tl;
            ier_r <= cfg_ier;
         end
         wb_addr_o    <= wb_addr_s;
         wb_dat_o     <= wb_dat_s;
         wb_we_o      <= wb_we_s;
         wb_re_o      <= wb_re_s;
         c0_ack       <= c0_ack_s;
         c1_ack       <= c1_ack_s;
         c0_rdata     <= c0_rdata_s;
         c1_rdata     <= c1_rdata_s;
         cfg_busy     <= busy_s;
         cfg_done     <= done_s;
      end
   end

   uart_bus_sched_chk #(.ADDR_WIDTH(ADDR_WIDTH)) u_chk (
      .clk      (clk),
      .rst      (wb_rst_i),
      .we       (wb_we_o),
      .re       (wb_re_o),
      .addr     (wb_addr_o),
      .dat      (wb_dat_o),
      .ack0     (c0_ack),
      .ack1     (c1_ack),
      .busy     (cfg_busy)
   );

endmodule

// Protocol properties of the scheduler's bus side
module uart_bus_sched_chk #(
   parameter int ADDR_WIDTH = 3
) (
   input logic                  clk,
   input logic                  rst,
   input logic                  we,
   input logic                  re,
   input logic [ADDR_WIDTH-1:0] addr,
   input logic [7:0]            dat,
   input logic                  ack0,
   input logic                  ack1,
   input logic                  busy
);

   a_one_strobe: assert property (@(posedge clk) disable iff (rst) !(we && re))
      else $error("read and write strobe together");
   a_gap: assert property (@(posedge clk) disable iff (rst) (we || re) |=> !(we || re))
      else $error("strobes in adjacent cycles");
   a_quiet_bus: assert property (@(posedge clk) disable iff (rst)
      !(we || re) |-> ((addr == {ADDR_WIDTH{1'b0}}) && (dat == 8'h00)))
      else $error("address or data driven outside a strobe");
   a_one_ack: assert property (@(posedge clk) disable iff (rst) !(ack0 && ack1))
      else $error("both clients acked together");
   a_no_ack_busy: assert property (@(posedge clk) disable iff (rst) busy |-> !(ack0 || ack1))
      else $error("client ack during init");

endmodule

// File: tb/tb_uart_bus_sched.sv
// Scenario bench for uart_bus_sched: expected bus strobes are queued as stimulus is applied
// and checked in order by a bus monitor; each task checks its own handshake timing.

module tb_uart_bus_sched;

   logic       clk = 1'b0;
   logic       wb_rst_i = 1'b1;
   logic       cfg_start = 1'b0;
   logic [15:0] cfg_divisor = 16'h0000;
   logic [7:0] cfg_lcr = 8'h00;
   logic [1:0] cfg_fcr_tl = 2'b00;
   logic [3:0] cfg_ier = 4'h0;
   logic       cfg_busy, cfg_done;
   logic       c0_req = 1'b0, c0_we = 1'b0, c1_req = 1'b0, c1_we = 1'b0;
   logic [2:0] c0_addr = 3'd0, c1_addr = 3'd0;
   logic [7:0] c0_wdata = 8'h00, c1_wdata = 8'h00;
   logic       c0_ack, c1_ack;
   logic [7:0] c0_rdata, c1_rdata;
   logic [2:0] wb_addr_o;
   logic [7:0] wb_dat_o, wb_dat_i;
   logic       wb_we_o, wb_re_o;

   logic [7:0]  rd_mem [0:7];
   logic [12:0] exp_q [$];
   logic [12:0] mon_v;
   logic        prev_strobe = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   assign wb_dat_i = rd_mem[wb_addr_o];

   uart_bus_sched #(.ADDR_WIDTH(3), .AUTO_INIT(1'b1)) dut (
      .clk(clk), .wb_rst_i(wb_rst_i), .cfg_start(cfg_start), .cfg_divisor(cfg_divisor),
      .cfg_lcr(cfg_lcr), .cfg_fcr_tl(cfg_fcr_tl), .cfg_ier(cfg_ier),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done),
      .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
      .c0_ack(c0_ack), .c0_rdata(c0_rdata),
      .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
      .c1_ack(c1_ack), .c1_rdata(c1_rdata),
      .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_re_o(wb_re_o),
      .wb_dat_i(wb_dat_i)
   );

   function automatic logic [12:0] ew(input logic [2:0] a, input logic [7:0] d);
      return {2'b10, a, d};
   endfunction

   function automatic logic [12:0] er(input logic [2:0] a);
      return {2'b01, a, 8'h00};
   endfunction

   // bus monitor: every strobe must be the next queued one and never follow another strobe
   always @(negedge clk) begin
      if ((wb_we_o || wb_re_o) === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL strobe_unexpected got we=%0b re=%0b addr=%0d dat=%h want none",
                     wb_we_o, wb_re_o, wb_addr_o, wb_dat_o);
         end else begin
            mon_v = exp_q.pop_front();
            if ({wb_we_o, wb_re_o, wb_addr_o, wb_dat_o} !== mon_v) begin
               n_bad++;
               $display("FAIL strobe_content got we=%0b re=%0b addr=%0d dat=%h want we=%0b re=%0b addr=%0d dat=%h",
                        wb_we_o, wb_re_o, wb_addr_o, wb_dat_o, mon_v[12], mon_v[11], mon_v[10:8], mon_v[7:0]);
            end
         end
         n_cmp++;
         if (prev_strobe !== 1'b0) begin
            n_bad++;
            $display("FAIL strobe_adjacent got strobe in consecutive cycles want idle gap");
         end
      end
      prev_strobe = ((wb_we_o || wb_re_o) === 1'b1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_init(input logic [15:0] d, input logic [7:0] l, input logic [1:0] t,
                            input logic [3:0] ie);
      exp_q.push_back(ew(3'd3, {1'b1, l[6:0]}));
      exp_q.push_back(ew(3'd0, d[7:0]));
      exp_q.push_back(ew(3'd1, d[15:8]));
      exp_q.push_back(ew(3'd3, {1'b0, l[6:0]}));
      exp_q.push_back(ew(3'd2, {t, 6'b000110}));
      exp_q.push_back(ew(3'd1, {4'h0, ie}));
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1;
      cfg_divisor = 16'h0145; cfg_lcr = 8'h03; cfg_fcr_tl = 2'b10; cfg_ier = 4'h5;
      repeat (3) tick();
      n_cmp++;
      if ({wb_we_o, wb_re_o, wb_addr_o, wb_dat_o} !== 13'h0000) begin
         n_bad++; $display("FAIL reset_bus got %h want 0000", {wb_we_o, wb_re_o, wb_addr_o, wb_dat_o});
      end
      n_cmp++;
      if ({c0_ack, c1_ack, cfg_busy, cfg_done} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_flags got %b want 0000", {c0_ack, c1_ack, cfg_busy, cfg_done});
      end
      n_cmp++;
      if ({c0_rdata, c1_rdata} !== 16'h0000) begin
         n_bad++; $display("FAIL reset_rdata got %h want 0000", {c0_rdata, c1_rdata});
      end
   endtask

   task automatic test_init();
      int cnt = 0;
      exp_q.push_back(ew(3'd3, 8'h83));
      exp_q.push_back(ew(3'd0, 8'h45));
      exp_q.push_back(ew(3'd1, 8'h01));
      exp_q.push_back(ew(3'd3, 8'h03));
      exp_q.push_back(ew(3'd2, 8'h86));
      exp_q.push_back(ew(3'd1, 8'h05));
      wb_rst_i = 1'b0;
      tick();
      n_cmp++;
      if ({wb_we_o, cfg_busy} !== 2'b11) begin
         n_bad++; $display("FAIL init_first_strobe got we=%0b busy=%0b want 1 1", wb_we_o, cfg_busy);
      end
      while (cfg_busy === 1'b1 && cnt < 20) begin
         cnt++;
         tick();
      end
      n_cmp++;
      if (cnt != 12) begin
         n_bad++; $display("FAIL init_busy_len got %0d want 12", cnt);
      end
      n_cmp++;
      if (cfg_done !== 1'b1) begin
         n_bad++; $display("FAIL init_done got %b want 1", cfg_done);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL init_all_strobes got %0d left want 0", exp_q.size());
      end
   endtask

   task automatic test_round_robin();
      int k0 = 0, k1 = 0, nexp = 0, cyc = 0, last_s = -1, bad_gap = 0;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(ew(3'd7, 8'(8'h10 + k)));
         exp_q.push_back(ew(3'd4, 8'(8'h20 + k)));
      end
      c0_we = 1'b1; c0_addr = 3'd7; c0_wdata = 8'h10; c0_req = 1'b1;
      c1_we = 1'b1; c1_addr = 3'd4; c1_wdata = 8'h20; c1_req = 1'b1;
      while ((k0 < 4 || k1 < 4) && cyc < 60) begin
         tick();
         cyc++;
         if (wb_we_o === 1'b1) begin
            if (last_s >= 0 && cyc - last_s != 2) bad_gap++;
            last_s = cyc;
         end
         if (c0_ack === 1'b1) begin
            n_cmp++;
            if (nexp != 0) begin
               n_bad++; $display("FAIL rr_order got client 0 want client %0d", nexp);
            end
            nexp = 1; k0++;
            if (k0 == 4) c0_req = 1'b0;
            else c0_wdata = 8'(8'h10 + k0);
         end
         if (c1_ack === 1'b1) begin
            n_cmp++;
            if (nexp != 1) begin
               n_bad++; $display("FAIL rr_order got client 1 want client %0d", nexp);
            end
            nexp = 0; k1++;
            if (k1 == 4) c1_req = 1'b0;
            else c1_wdata = 8'(8'h20 + k1);
         end
      end
      n_cmp++;
      if (k0 != 4 || k1 != 4) begin
         n_bad++; $display("FAIL rr_timeout got acks %0d/%0d want 4/4", k0, k1);
      end
      n_cmp++;
      if (bad_gap != 0) begin
         n_bad++; $display("FAIL rr_spacing got %0d uneven strobe gaps want 0", bad_gap);
      end
      c0_req = 1'b0; c1_req = 1'b0;
   endtask

   task automatic test_read();
      repeat (2) tick();
      rd_mem[5] = 8'h60;
      exp_q.push_back(er(3'd5));
      c0_we = 1'b0; c0_addr = 3'd5; c0_wdata = 8'h00; c0_req = 1'b1;
      tick();
      n_cmp++;
      if ({wb_re_o, c0_ack} !== 2'b10) begin
         n_bad++; $display("FAIL rd_strobe got re=%0b ack=%0b want 1 0", wb_re_o, c0_ack);
      end
      tick();
      n_cmp++;
      if ({wb_re_o, c0_ack, c0_rdata} !== {2'b01, 8'h60}) begin
         n_bad++; $display("FAIL rd_ack got re=%0b ack=%0b rdata=%h want 0 1 60", wb_re_o, c0_ack, c0_rdata);
      end
      c0_req = 1'b0;
      tick();
      n_cmp++;
      if ({c0_ack, c0_rdata} !== {1'b0, 8'h60}) begin
         n_bad++; $display("FAIL rd_hold got ack=%0b rdata=%h want 0 60", c0_ack, c0_rdata);
      end
      // a write must leave the last read data in place
      exp_q.push_back(ew(3'd6, 8'h99));
      c0_we = 1'b1; c0_addr = 3'd6; c0_wdata = 8'h99; c0_req = 1'b1;
      repeat (2) tick();
      n_cmp++;
      if ({c0_ack, c0_rdata} !== {1'b1, 8'h60}) begin
         n_bad++; $display("FAIL wr_keeps_rdata got ack=%0b rdata=%h want 1 60", c0_ack, c0_rdata);
      end
      c0_req = 1'b0;
   endtask

   task automatic test_cfg_start_mid();
      int cyc = 0, fall = -1, ackc = -1;
      logic seen_busy = 1'b0;
      repeat (2) tick();
      cfg_divisor = 16'h1234; cfg_lcr = 8'h9B; cfg_fcr_tl = 2'b01; cfg_ier = 4'hA;
      exp_q.push_back(ew(3'd6, 8'hA5));
      push_init(16'h1234, 8'h9B, 2'b01, 4'hA);
      exp_q.push_back(ew(3'd7, 8'h3C));
      c1_we = 1'b1; c1_addr = 3'd6; c1_wdata = 8'hA5; c1_req = 1'b1;
      tick();
      cfg_start = 1'b1;
      c0_we = 1'b1; c0_addr = 3'd7; c0_wdata = 8'h3C; c0_req = 1'b1;
      tick();
      cfg_start = 1'b0;
      n_cmp++;
      if (c1_ack !== 1'b1) begin
         n_bad++; $display("FAIL cs_c1_ack got %b want 1", c1_ack);
      end
      c1_req = 1'b0;
      repeat (2) tick();
      n_cmp++;
      if ({cfg_busy, wb_we_o} !== 2'b11) begin
         n_bad++; $display("FAIL cs_init_start got busy=%0b we=%0b want 1 1", cfg_busy, wb_we_o);
      end
      // late config changes and a start pulse while busy must both be ignored
      cfg_divisor = 16'hFFFF; cfg_lcr = 8'hFF; cfg_fcr_tl = 2'b11; cfg_ier = 4'hF;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      while (ackc < 0 && cyc < 40) begin
         if (cfg_busy === 1'b1) seen_busy = 1'b1;
         if (cfg_busy === 1'b0 && seen_busy && fall < 0) fall = cyc;
         if (c0_ack === 1'b1) ackc = cyc;
         if (ackc < 0) begin
            tick();
            cyc++;
         end
      end
      n_cmp++;
      if (ackc < 0 || fall < 0 || ackc != fall + 2) begin
         n_bad++; $display("FAIL cs_c0_after_init got ack@%0d busy_fall@%0d want ack 2 after fall", ackc, fall);
      end
      c0_req = 1'b0;
      repeat (6) tick();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL cs_all_strobes got %0d left want 0", exp_q.size());
      end
   endtask

   task automatic test_reset_in_strobe();
      repeat (2) tick();
      exp_q.push_back(ew(3'd1, 8'h77));
      c0_we = 1'b1; c0_addr = 3'd1; c0_wdata = 8'h77; c0_req = 1'b1;
      tick();
      n_cmp++;
      if (wb_we_o !== 1'b1) begin
         n_bad++; $display("FAIL rs_strobe got we=%0b want 1", wb_we_o);
      end
      wb_rst_i = 1'b1;
      c0_req = 1'b0;
      tick();
      n_cmp++;
      if ({wb_we_o, wb_re_o, wb_addr_o, wb_dat_o, c0_ack, c1_ack, cfg_busy, cfg_done} !== 17'h00000) begin
         n_bad++; $display("FAIL rs_outputs got %h want 00000",
                           {wb_we_o, wb_re_o, wb_addr_o, wb_dat_o, c0_ack, c1_ack, cfg_busy, cfg_done});
      end
      n_cmp++;
      if (c0_rdata !== 8'h00) begin
         n_bad++; $display("FAIL rs_rdata got %h want 00", c0_rdata);
      end
      cfg_divisor = 16'hABCD; cfg_lcr = 8'h1F; cfg_fcr_tl = 2'b11; cfg_ier = 4'h3;
      push_init(16'hABCD, 8'h1F, 2'b11, 4'h3);
      wb_rst_i = 1'b0;
      tick();
      n_cmp++;
      if ({wb_we_o, wb_addr_o, c0_ack} !== {1'b1, 3'd3, 1'b0}) begin
         n_bad++; $display("FAIL rs_rerun got we=%0b addr=%0d ack=%0b want 1 3 0", wb_we_o, wb_addr_o, c0_ack);
      end
      repeat (14) tick();
      n_cmp++;
      if ({cfg_done, exp_q.size() == 0} !== 2'b11) begin
         n_bad++; $display("FAIL rs_done got done=%0b left=%0d want 1 0", cfg_done, exp_q.size());
      end
   endtask

   task automatic test_early_req();
      int cyc = 0, fall = -1, ackc = -1;
      logic seen_busy = 1'b0;
      rd_mem[2] = 8'hC3;
      wb_rst_i = 1'b1;
      tick();
      push_init(cfg_divisor, cfg_lcr, cfg_fcr_tl, cfg_ier);
      exp_q.push_back(er(3'd2));
      wb_rst_i = 1'b0;
      c1_we = 1'b0; c1_addr = 3'd2; c1_wdata = 8'h00; c1_req = 1'b1;
      tick();
      n_cmp++;
      if ({cfg_busy, cfg_done} !== 2'b10) begin
         n_bad++; $display("FAIL er_busy_first got busy=%0b done=%0b want 1 0", cfg_busy, cfg_done);
      end
      while (ackc < 0 && cyc < 40) begin
         if (cfg_busy === 1'b1) seen_busy = 1'b1;
         if (cfg_busy === 1'b0 && seen_busy && fall < 0) fall = cyc;
         if (c1_ack === 1'b1) ackc = cyc;
         if (ackc < 0) begin
            tick();
            cyc++;
         end
      end
      n_cmp++;
      if (ackc < 0 || fall < 0 || ackc != fall + 2) begin
         n_bad++; $display("FAIL er_ack_timing got ack@%0d done@%0d want ack 2 after done", ackc, fall);
      end
      n_cmp++;
      if ({c1_rdata, cfg_done} !== {8'hC3, 1'b1}) begin
         n_bad++; $display("FAIL er_rdata got rdata=%h done=%0b want c3 1", c1_rdata, cfg_done);
      end
      c1_req = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL er_all_strobes got %0d left want 0", exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rd_mem[i] = 8'(8'h40 + i);
      test_reset();
      test_init();
      test_round_robin();
      test_read();
      test_cfg_start_mid();
      test_reset_in_strobe();
      test_early_req();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no completion want finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
